// File: rtl/debug_mem_sequencer_pkg.sv
// Shared types and helpers for the debug BRAM sequencer.
package debug_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_I     = 4'd1,
    ST_LOAD_D     = 4'd2,
    ST_CORE_RST   = 4'd3,
    ST_RUN        = 4'd4,
    ST_DUMP_ISSUE = 4'd5,
    ST_DUMP_WAIT  = 4'd6,
    ST_DUMP_HOLD  = 4'd7,
    ST_DONE       = 4'd8
  } seq_state_t;

  localparam logic [3:0] BYTE_WE_ALL = 4'b1111;
  localparam logic       SEL_DATA    = 1'b0;
  localparam logic       SEL_INST    = 1'b1;

  // Word index to byte address on the debug ports.
  function automatic logic [31:0] idx_to_addr(input logic [29:0] idx);
    return {idx, 2'b00};
  endfunction

endpackage

// File: rtl/debug_mem_sequencer_if.sv
// Host-side load and dump streams of the debug sequencer.
interface debug_mem_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_sel;

  // Host / UART bridge side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_sel
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_sel
  );
endinterface

// File: rtl/debug_mem_sequencer_counter.sv
// Loadable down-counter with a zero flag; used to time core reset and run phases.
module dbg_cycle_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/debug_mem_sequencer.sv
// Loads InstRAM/DataRAM images from the host, pulses core reset, runs the core
// for a fixed budget, then dumps DataRAM followed by InstRAM to the host.
module debug_mem_sequencer
  import debug_seq_pkg::*;
#(
  parameter int unsigned BRAM_WORDS = 4096,
  parameter int unsigned RST_CYCLES = 5,
  parameter int unsigned RUN_CYCLES = 200000
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST_N,
  input  logic                  start,
  debug_mem_sequencer_if.slave  hostBus,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           dram_a2,
  output logic [31:0]           iram_a2,
  output logic [31:0]           dram_wd2,
  output logic [31:0]           iram_wd2,
  output logic [3:0]            dram_we2,
  output logic [3:0]            iram_we2,
  input  logic [31:0]           dram_rd2,
  input  logic [31:0]           iram_rd2
);

  localparam int unsigned IW       = $clog2(BRAM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BRAM_WORDS - 1);
  localparam logic [31:0]   RST_LOAD = 32'(RST_CYCLES - 1);
  localparam logic [31:0]   RUN_LOAD = 32'(RUN_CYCLES - 1);

  seq_state_t    state;
  logic [IW-1:0] idx;
  logic          outSel;
  logic [31:0]   outData;
  logic [31:0]   outAddr;

  logic        loadI;
  logic        loadD;
  logic        inHs;
  logic        loadEnd;
  logic        dumping;
  logic [31:0] curAddr;
  logic        cntLoad;
  logic [31:0] cntValue;
  logic        cntDec;
  logic        cntZero;

  assign loadI   = (state == ST_LOAD_I);
  assign loadD   = (state == ST_LOAD_D);
  assign inHs    = hostBus.in_valid && (loadI || loadD);
  assign loadEnd = hostBus.in_last || (idx == LAST_IDX);
  assign dumping = (state == ST_DUMP_ISSUE) || (state == ST_DUMP_WAIT) ||
                   (state == ST_DUMP_HOLD);
  assign curAddr = idx_to_addr(30'(idx));

  // Counter is armed when entering CORE_RST and re-armed when entering RUN.
  always_comb begin
    cntLoad  = 1'b0;
    cntValue = '0;
    if (loadD && inHs && loadEnd) begin
      cntLoad  = 1'b1;
      cntValue = RST_LOAD;
    end else if ((state == ST_CORE_RST) && cntZero) begin
      cntLoad  = 1'b1;
      cntValue = RUN_LOAD;
    end
  end

  assign cntDec = (state == ST_CORE_RST) || (state == ST_RUN);

  dbg_cycle_counter #(.WIDTH(32)) phaseCounter (
    .clk       (CPU_CLK),
    .rst_n     (CPU_RST_N),
    .load      (cntLoad),
    .loadValue (cntValue),
    .dec       (cntDec),
    .zero      (cntZero)
  );

  // Main sequencing FSM with word index, dump select and dump output registers.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state   <= ST_IDLE;
      idx     <= '0;
      outSel  <= SEL_DATA;
      outData <= '0;
      outAddr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_LOAD_I;
            idx    <= '0;
            outSel <= SEL_DATA;
          end
        end
        ST_LOAD_I, ST_LOAD_D: begin
          if (inHs) begin
            if (loadEnd) begin
              idx   <= '0;
              state <= loadI ? ST_LOAD_D : ST_CORE_RST;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_CORE_RST: begin
          if (cntZero) state <= ST_RUN;
        end
        ST_RUN: begin
          if (cntZero) begin
            state  <= ST_DUMP_ISSUE;
            idx    <= '0;
            outSel <= SEL_DATA;
          end
        end
        ST_DUMP_ISSUE: state <= ST_DUMP_WAIT;
        ST_DUMP_WAIT: begin
          outData <= (outSel == SEL_INST) ? iram_rd2 : dram_rd2;
          outAddr <= curAddr;
          state   <= ST_DUMP_HOLD;
        end
        ST_DUMP_HOLD: begin
          if (hostBus.out_ready) begin
            if (idx != LAST_IDX) begin
              idx   <= idx + IW'(1);
              state <= ST_DUMP_ISSUE;
            end else if (outSel == SEL_DATA) begin
              outSel <= SEL_INST;
              idx    <= '0;
              state  <= ST_DUMP_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // a2 follows idx for the RAM being loaded or dumped, and stays put through a dump stall.
  assign iram_a2  = (loadI || (dumping && (outSel == SEL_INST))) ? curAddr : '0;
  assign dram_a2  = (loadD || (dumping && (outSel == SEL_DATA))) ? curAddr : '0;
  assign iram_we2 = (loadI && inHs) ? BYTE_WE_ALL : '0;
  assign dram_we2 = (loadD && inHs) ? BYTE_WE_ALL : '0;
  assign iram_wd2 = (loadI && inHs) ? hostBus.in_data : '0;
  assign dram_wd2 = (loadD && inHs) ? hostBus.in_data : '0;

  assign hostBus.in_ready  = loadI || loadD;
  assign hostBus.out_valid = (state == ST_DUMP_HOLD);
  assign hostBus.out_data  = outData;
  assign hostBus.out_addr  = outAddr;
  assign hostBus.out_sel   = outSel;

  assign core_rst = (state != ST_RUN);
  assign busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// Self-checking bench for debug_mem_sequencer with behavioural BRAMs and a
// phase-level reference model of load, reset/run timing and dump ordering.
module tb_debug_mem_sequencer;

  localparam int BW   = 16;
  localparam int RSTC = 5;
  localparam int RUNC = 10;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N = 1'b0;
  logic        start = 1'b0;
  logic        core_rst, busy, done;
  logic [31:0] dram_a2, iram_a2, dram_wd2, iram_wd2, dram_rd2, iram_rd2;
  logic [3:0]  dram_we2, iram_we2;

  debug_mem_sequencer_if hostIf();

  debug_mem_sequencer #(.BRAM_WORDS(BW), .RST_CYCLES(RSTC), .RUN_CYCLES(RUNC)) dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .start    (start),
    .hostBus  (hostIf),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .dram_a2  (dram_a2),
    .iram_a2  (iram_a2),
    .dram_wd2 (dram_wd2),
    .iram_wd2 (iram_wd2),
    .dram_we2 (dram_we2),
    .iram_we2 (iram_we2),
    .dram_rd2 (dram_rd2),
    .iram_rd2 (iram_rd2)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Behavioural BRAMs: registered byte-lane write, one-cycle registered read.
  logic [31:0] bramI [BW];
  logic [31:0] bramD [BW];
  always @(posedge CPU_CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (iram_we2[b]) bramI[iram_a2[5:2]][8*b +: 8] <= iram_wd2[8*b +: 8];
      if (dram_we2[b]) bramD[dram_a2[5:2]][8*b +: 8] <= dram_wd2[8*b +: 8];
    end
    iram_rd2 <= bramI[iram_a2[5:2]];
    dram_rd2 <= dram_a2 == 32'h0 ? bramD[0] : bramD[dram_a2[5:2]];
  end

  // Reference contents of each RAM.
  logic [31:0] modelI [BW];
  logic [31:0] modelD [BW];

  int nCompared = 0;
  int nMismatch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 load inst, 2 load data, 3 core reset, 4 run, 5 dump, 6 done.
  int phase = 0;
  int loadIdx = 0;
  int rstCnt = 0;
  int runCnt = 0;
  int gap = 0;
  int dumpCount = 0;
  int runId = 0;
  bit bpDone = 1'b0;

  // Compare process: checks every DUT output against the model once per cycle.
  always @(negedge CPU_CLK) begin
    int ph;
    bit expReady, hs, sel;
    logic [31:0] expWord;
    if (!CPU_RST_N) begin
      phase = 0; loadIdx = 0; dumpCount = 0; gap = 0;
    end else begin
      ph = phase;
      expReady = (ph == 1) || (ph == 2);
      check("in_ready", 32'(hostIf.in_ready), 32'(expReady));
      check("busy", 32'(busy), 32'((ph != 0) && (ph != 6)));
      check("done", 32'(done), 32'(ph == 6));
      hs = hostIf.in_valid && expReady;
      check("iram_we2", 32'(iram_we2), (hs && ph == 1) ? 32'hF : 32'h0);
      check("dram_we2", 32'(dram_we2), (hs && ph == 2) ? 32'hF : 32'h0);
      if (ph != 4 && ph != 3) check("core_rst", 32'(core_rst), 32'h1);
      if (ph != 5) check("out_valid_idle", 32'(hostIf.out_valid), 32'h0);
      if (hs) begin
        check("load_a2", (ph == 1) ? iram_a2 : dram_a2, 32'(loadIdx * 4));
        check("load_wd2", (ph == 1) ? iram_wd2 : dram_wd2, hostIf.in_data);
        if (ph == 1) modelI[loadIdx] = hostIf.in_data;
        else         modelD[loadIdx] = hostIf.in_data;
        if (hostIf.in_last || loadIdx == BW - 1) begin
          loadIdx = 0;
          phase = ph + 1;
          rstCnt = 0;
        end else begin
          loadIdx++;
        end
      end
      if (ph == 3) begin
        if (core_rst) rstCnt++;
        else begin
          check("rst_len", 32'(rstCnt), 32'(RSTC));
          phase = 4; runCnt = 1;
        end
      end
      if (ph == 4) begin
        if (!core_rst) runCnt++;
        else begin
          check("run_len", 32'(runCnt), 32'(RUNC));
          phase = 5; gap = 0; dumpCount = 0;
        end
      end
      if (phase == 5) begin
        gap++;
        sel = (dumpCount >= BW);
        expWord = sel ? modelI[dumpCount % BW] : modelD[dumpCount % BW];
        check("out_valid", 32'(hostIf.out_valid), 32'(gap >= 3));
        if (gap == 1 || hostIf.out_valid)
          check("dump_a2", sel ? iram_a2 : dram_a2, 32'((dumpCount % BW) * 4));
        if (hostIf.out_valid) begin
          check("out_sel", 32'(hostIf.out_sel), 32'(sel));
          check("out_addr", hostIf.out_addr, 32'((dumpCount % BW) * 4));
          check("out_data", hostIf.out_data, expWord);
          if (hostIf.out_ready) begin
            if (runId == 1 && dumpCount == 0)  check("pin_d0", hostIf.out_data, 32'h00000011);
            if (runId == 1 && dumpCount == 1)  check("pin_d1", hostIf.out_data, 32'h00000022);
            if (runId == 1 && dumpCount == BW) check("pin_i0", hostIf.out_data, 32'h00000013);
            if (runId == 1 && dumpCount == BW + 1) check("pin_i1", hostIf.out_data, 32'h00100093);
            dumpCount++;
            gap = 0;
            if (dumpCount == 2 * BW) phase = 6;
          end
        end
      end
      if (start && (ph == 0 || ph == 6)) begin
        phase = 1; loadIdx = 0;
      end
    end
  end

  // Dump-side backpressure: random, plus one directed 7-cycle stall on word 4 of run 1.
  initial begin
    hostIf.out_ready = 1'b0;
    forever begin
      @(posedge CPU_CLK); #1;
      if (runId == 1 && dumpCount == 4 && !bpDone && hostIf.out_valid) begin
        hostIf.out_ready = 1'b0;
        repeat (7) @(posedge CPU_CLK);
        #1;
        bpDone = 1'b1;
        hostIf.out_ready = 1'b1;
      end else begin
        hostIf.out_ready = ($urandom % 4) != 0;
      end
    end
  end

  task automatic pulseStart();
    @(posedge CPU_CLK); #1; start = 1'b1;
    @(posedge CPU_CLK); #1; start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last);
    bit ok;
    repeat ($urandom % 3) begin
      @(posedge CPU_CLK); #1;
    end
    hostIf.in_valid = 1'b1;
    hostIf.in_data  = d;
    hostIf.in_last  = last;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge CPU_CLK); ok = hostIf.in_ready;
      @(posedge CPU_CLK); #1;
    end
    if (!ok) begin
      nCompared++; nMismatch++;
      $display("FAIL load_timeout: in_ready never seen for word %h", d);
    end
    hostIf.in_valid = 1'b0;
    hostIf.in_last  = 1'b0;
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge CPU_CLK); #1;
      seen = done;
    end
    if (!seen) begin
      nCompared++; nMismatch++;
      $display("FAIL done_timeout: done still %b after 3000 cycles", done);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_core_rst"}, 32'(core_rst), 32'h1);
    check({tag, "_in_ready"}, 32'(hostIf.in_ready), 32'h0);
    check({tag, "_out_valid"}, 32'(hostIf.out_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_out_data"}, hostIf.out_data, 32'h0);
    check({tag, "_out_addr"}, hostIf.out_addr, 32'h0);
    check({tag, "_out_sel"}, 32'(hostIf.out_sel), 32'h0);
    check({tag, "_iram_a2"}, iram_a2, 32'h0);
    check({tag, "_dram_a2"}, dram_a2, 32'h0);
    check({tag, "_we2"}, {24'h0, iram_we2, dram_we2}, 32'h0);
    check({tag, "_wd2"}, iram_wd2 | dram_wd2, 32'h0);
  endtask

  initial begin
    bit hit;
    hostIf.in_valid = 1'b0;
    hostIf.in_data  = '0;
    hostIf.in_last  = 1'b0;
    for (int i = 0; i < BW; i++) begin
      bramI[i] = $urandom; modelI[i] = bramI[i];
      bramD[i] = $urandom; modelD[i] = bramD[i];
    end

    // Start while held in reset must be ignored.
    repeat (2) @(posedge CPU_CLK);
    #1; start = 1'b1;
    @(posedge CPU_CLK); #1; start = 1'b0;
    checkResetValues("por");
    @(posedge CPU_CLK); #1; CPU_RST_N = 1'b1;
    repeat (4) @(posedge CPU_CLK);
    #1; check("idle_after_rst", 32'(busy), 32'h0);

    // Run 1: directed short images.
    runId = 1;
    pulseStart();
    sendWord(32'h00000013, 1'b0);
    sendWord(32'h00100093, 1'b0);
    sendWord(32'hDEADBEEF, 1'b1);
    sendWord(32'h00000011, 1'b0);
    sendWord(32'h00000022, 1'b1);
    waitDone();
    check("run1_bp_exercised", 32'(bpDone), 32'h1);

    // Run 2: full inst image with no in_last; next word lands in DataRAM[0].
    runId = 2;
    pulseStart();
    for (int i = 0; i < BW; i++) sendWord($urandom, 1'b0);
    sendWord($urandom, 1'b1);
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge CPU_CLK); #1;
      hit = (phase == 5) && (dumpCount == 5);
    end
    if (!hit) begin
      nCompared++; nMismatch++;
      $display("FAIL dump_idx5_timeout: dump never reached word 5");
    end
    #1; CPU_RST_N = 1'b0;
    #1; checkResetValues("midrst");
    repeat (3) @(posedge CPU_CLK);
    #1; CPU_RST_N = 1'b1;

    // Run 3: random partial images after the abandoned dump.
    runId = 3;
    pulseStart();
    begin
      int nI, nD;
      nI = 1 + int'($urandom % 5);
      nD = 1 + int'($urandom % 5);
      for (int i = 0; i < nI; i++) sendWord($urandom, i == nI - 1);
      for (int i = 0; i < nD; i++) sendWord($urandom, i == nD - 1);
    end
    waitDone();
    check("run3_done", 32'(done), 32'h1);
    check("run3_handshakes", 32'(dumpCount), 32'(2 * BW));

    repeat (2) @(posedge CPU_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
